fb_writer: RTL

Framebuffer write stage directly downstream of the rasterizer. It accepts the rasterizer's pixel/colour stream over a valid/ready handshake and converts each pixel coordinate to a linear framebuffer address. It drops out-of-bounds pixels and drives a single-port framebuffer write interface. It also runs a clear sequencer that fills the whole framebuffer with a clear colour on request.

---
 rtl/fb_writer_pkg.sv | 33 +++
 rtl/fb_writer_clear_seq.sv | 56 +++++
 rtl/fb_writer.sv | 127 ++++++++++++
 3 files changed

// File: rtl/fb_writer_pkg.sv
// Shared types and constants for the framebuffer write stage.
// Coordinates are signed fixed point; the integer pixel index sits above FX_FRAC_BITS.
package fb_writer_pkg;

    localparam int DEF_FB_WIDTH  = 320;
    localparam int DEF_FB_HEIGHT = 240;
    localparam int COLOR_BITS    = 16;
    localparam int COORD_BITS    = 16;
    localparam int FX_FRAC_BITS  = 4;
    localparam int INT_BITS      = COORD_BITS - FX_FRAC_BITS;

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        CLEAR
    } fb_state_t;

    typedef struct packed {
        logic signed [COORD_BITS-1:0] x;
        logic signed [COORD_BITS-1:0] y;
    } coord_2d_t;

    typedef struct packed {
        coord_2d_t               pos;
        logic [COLOR_BITS-1:0]   color;
    } pix_req_t;

    // Integer part of a fixed-point coordinate field (floor for negatives).
    function automatic logic signed [INT_BITS-1:0] coord_int(input logic signed [COORD_BITS-1:0] f);
        return f[COORD_BITS-1:FX_FRAC_BITS];
    endfunction

endpackage

// File: rtl/fb_writer_clear_seq.sv
// Clear sequencer: walks every framebuffer address once with a sampled fill colour.
// tail marks the cycle the final write is on the port; done follows one cycle later.
module fb_clear_seq
    import fb_writer_pkg::*;
#(
    parameter int DEPTH     = DEF_FB_WIDTH * DEF_FB_HEIGHT,
    parameter int ADDR_BITS = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [COLOR_BITS-1:0] clear_color,
    output logic                  wr,
    output logic [ADDR_BITS-1:0]  addr,
    output logic [COLOR_BITS-1:0] wdata,
    output logic                  tail,
    output logic                  done
);

    localparam logic [ADDR_BITS-1:0] LAST = ADDR_BITS'(DEPTH - 1);

    logic                  active;
    logic [ADDR_BITS-1:0]  cnt;
    logic [COLOR_BITS-1:0] color_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            active  <= 1'b0;
            cnt     <= '0;
            color_q <= '0;
            tail    <= 1'b0;
            done    <= 1'b0;
        end else begin
            tail <= 1'b0;
            done <= tail;
            if (start) begin
                active  <= 1'b1;
                cnt     <= '0;
                color_q <= clear_color;
            end else if (active) begin
                if (cnt == LAST) begin
                    active <= 1'b0;
                    cnt    <= '0;
                    tail   <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

    assign wr    = active;
    assign addr  = cnt;
    assign wdata = color_q;

endmodule

// File: rtl/fb_writer.sv
// Framebuffer write stage: two-stage pixel pipeline (decode, write) with bounds
// rejection, plus an FSM that drains the pipe before handing the port to the clear sequencer.
module fb_writer
    import fb_writer_pkg::*;
#(
    parameter int FB_WIDTH  = DEF_FB_WIDTH,
    parameter int FB_HEIGHT = DEF_FB_HEIGHT,
    parameter int ADDR_BITS = $clog2(FB_WIDTH * FB_HEIGHT)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  vld_in,
    output logic                  rdy_in,
    input  logic [COLOR_BITS-1:0] color_in,
    input  coord_2d_t             pixel_in,
    input  logic                  clear_req,
    input  logic [COLOR_BITS-1:0] clear_color,
    output logic                  fb_we,
    output logic [ADDR_BITS-1:0]  fb_addr,
    output logic [COLOR_BITS-1:0] fb_wdata,
    output logic                  busy,
    output logic                  clear_done,
    output logic [15:0]           dropped_count
);

    localparam int STAGES = 2;
    localparam int DEPTH  = FB_WIDTH * FB_HEIGHT;

    fb_state_t state, state_nxt;
    logic [STAGES-1:0] vld_pipe;
    pix_req_t          s1_q;
    logic              accept, clr_start;

    logic                  clr_wr, clr_tail;
    logic [ADDR_BITS-1:0]  clr_addr;
    logic [COLOR_BITS-1:0] clr_wdata;

    logic signed [INT_BITS-1:0] s1_x, s1_y;
    logic                       s1_inb;
    logic [ADDR_BITS:0]         s1_x_w, s1_y_w, s1_addr_w;
    logic [ADDR_BITS-1:0]       s1_addr;

    always_ff @(posedge clk) begin
        if (rst) state <= RUN;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        rdy_in    = 1'b0;
        busy      = (state != RUN) || clear_req;
        clr_start = 1'b0;
        unique case (state)
            RUN: begin
                rdy_in = !rst && !clear_req;
                if (clear_req) state_nxt = (|vld_pipe) ? DRAIN : CLEAR;
            end
            DRAIN: if (!(|vld_pipe)) state_nxt = CLEAR;
            CLEAR: if (clr_tail) state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
        clr_start = (state != CLEAR) && (state_nxt == CLEAR);
    end

    assign accept = vld_in && rdy_in;

    // Bounds are resolved first; the multiply only ever sees in-range, non-negative operands.
    always_comb begin
        s1_x   = coord_int(s1_q.pos.x);
        s1_y   = coord_int(s1_q.pos.y);
        s1_inb = !s1_x[INT_BITS-1] && !s1_y[INT_BITS-1] &&
                 (int'(s1_x) < FB_WIDTH) && (int'(s1_y) < FB_HEIGHT);
        s1_x_w = '0;
        s1_y_w = '0;
        if (s1_inb) begin
            s1_x_w = (ADDR_BITS+1)'(s1_x);
            s1_y_w = (ADDR_BITS+1)'(s1_y);
        end
        s1_addr_w = s1_y_w * (ADDR_BITS+1)'(FB_WIDTH) + s1_x_w;
        s1_addr   = s1_addr_w[ADDR_BITS-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe      <= '0;
            s1_q          <= '0;
            fb_we         <= 1'b0;
            fb_addr       <= '0;
            fb_wdata      <= '0;
            dropped_count <= '0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-2:0], accept};
            if (accept) s1_q <= '{pos: pixel_in, color: color_in};
            fb_we <= 1'b0;
            // The FSM only starts a clear with the pipe empty, so the two sources never collide.
            if (clr_wr) begin
                fb_we    <= 1'b1;
                fb_addr  <= clr_addr;
                fb_wdata <= clr_wdata;
            end else if (vld_pipe[0]) begin
                if (s1_inb) begin
                    fb_we    <= 1'b1;
                    fb_addr  <= s1_addr;
                    fb_wdata <= s1_q.color;
                end else if (dropped_count != 16'hFFFF) begin
                    dropped_count <= dropped_count + 16'd1;
                end
            end
        end
    end

    fb_clear_seq #(
        .DEPTH     (DEPTH),
        .ADDR_BITS (ADDR_BITS)
    ) u_clear_seq (
        .clk         (clk),
        .rst         (rst),
        .start       (clr_start),
        .clear_color (clear_color),
        .wr          (clr_wr),
        .addr        (clr_addr),
        .wdata       (clr_wdata),
        .tail        (clr_tail),
        .done        (clear_done)
    );

endmodule
